// File: rtl/wb_result_arbiter.sv
// Shared writeback stage: each FU result lands in a 2-entry FIFO, and a round-robin
// arbiter moves one buffered result per cycle into the registered wb_* outputs.
module wb_result_arbiter #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int FU_IDX_BITS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    fu_in_valid      [FU_COUNT],
    output logic                    fu_in_ready      [FU_COUNT],
    input  logic [INST_ID_BITS-1:0] fu_in_inst_id    [FU_COUNT],
    input  logic [PRN_BITS-1:0]     fu_in_prn        [FU_COUNT][MAX_OPERANDS],
    input  logic [63:0]             fu_in_data       [FU_COUNT][MAX_OPERANDS],
    input  logic                    fu_in_data_valid [FU_COUNT][MAX_OPERANDS],

    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [INST_ID_BITS-1:0] wb_inst_id,
    output logic [PRN_BITS-1:0]     wb_prn           [MAX_OPERANDS],
    output logic [63:0]             wb_data          [MAX_OPERANDS],
    output logic                    wb_data_valid    [MAX_OPERANDS],
    output logic [FU_IDX_BITS-1:0]  wb_fu_index
);

    typedef struct packed {
        logic [INST_ID_BITS-1:0]               inst_id;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
        logic [MAX_OPERANDS-1:0][63:0]         data;
        logic [MAX_OPERANDS-1:0]               data_valid;
    } result_t;

    result_t                in_res     [FU_COUNT];
    result_t                fifo_mem   [FU_COUNT][2];
    logic [1:0]             fifo_count [FU_COUNT];
    logic                   fifo_head  [FU_COUNT];
    logic                   fifo_tail  [FU_COUNT];
    logic                   push       [FU_COUNT];
    logic                   pop        [FU_COUNT];
    logic                   req        [FU_COUNT];

    logic                   adv;
    logic                   grant_valid;
    logic [FU_IDX_BITS-1:0] grant_idx;
    logic [FU_IDX_BITS-1:0] cand;
    logic [FU_IDX_BITS-1:0] rr_ptr;
    logic [FU_IDX_BITS-1:0] rr_next;
    result_t                wb_q;

    // Flatten each FU's port bundle into one record so the FIFO stores it as a unit.
    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            in_res[i]         = '0;
            in_res[i].inst_id = fu_in_inst_id[i];
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                in_res[i].prn[k]        = fu_in_prn[i][k];
                in_res[i].data[k]       = fu_in_data[i][k];
                in_res[i].data_valid[k] = fu_in_data_valid[i][k];
            end
        end
    end

    // Ready depends only on the registered count, so an FU never pushes into a full FIFO.
    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            fu_in_ready[i] = (fifo_count[i] != 2'd2);
            push[i]        = fu_in_valid[i] && fu_in_ready[i];
            req[i]         = (fifo_count[i] != 2'd0);
            fifo_tail[i]   = fifo_head[i] ^ fifo_count[i][0];
        end
    end

    assign adv = !wb_valid || wb_ready;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            cand = FU_IDX_BITS'((int'(rr_ptr) + i) % FU_COUNT);
            if (adv && !grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            pop[i] = grant_valid && (grant_idx == FU_IDX_BITS'(i));
        end
    end

    assign rr_next = (grant_idx == FU_IDX_BITS'(FU_COUNT - 1)) ? '0 : grant_idx + 1'b1;

    // NOTE: all state updates in clocked blocks use non-blocking assignments so
    // every register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FU_COUNT; i++) begin
                fifo_count[i] <= 2'd0;
                fifo_head[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < FU_COUNT; i++) begin
                if (pop[i]) begin
                    fifo_head[i] <= ~fifo_head[i];
                end
                if (push[i] && !pop[i]) begin
                    fifo_count[i] <= fifo_count[i] + 2'd1;
                end else if (!push[i] && pop[i]) begin
                    fifo_count[i] <= fifo_count[i] - 2'd1;
                end
            end
        end
    end

    // NOTE: the FIFO payload storage has no reset; an entry is only ever read
    // after being written, and the reset counts already mark it empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_COUNT; i++) begin
            if (push[i]) begin
                fifo_mem[i][fifo_tail[i]] <= in_res[i];
            end
        end
    end

    // Writeback register: loads only on a grant, so a stall holds every field stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_q        <= '0;
            wb_fu_index <= '0;
            rr_ptr      <= '0;
        end else if (adv) begin
            if (grant_valid) begin
                wb_valid    <= 1'b1;
                wb_q        <= fifo_mem[grant_idx][fifo_head[grant_idx]];
                wb_fu_index <= grant_idx;
                rr_ptr      <= rr_next;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        wb_inst_id = wb_q.inst_id;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            wb_prn[k]        = wb_q.prn[k];
            wb_data[k]       = wb_q.data[k];
            wb_data_valid[k] = wb_q.data_valid[k];
        end
    end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for latency, ordering, backpressure and reset.
module tb_wb_result_arbiter;

    localparam int IDB = 6;
    localparam int PB  = 6;
    localparam int OPS = 3;
    localparam int FUS = 4;
    localparam int IXB = 2;

    typedef struct packed {
        logic [IDB-1:0]          id;
        logic [OPS-1:0][PB-1:0]  prn;
        logic [OPS-1:0][63:0]    data;
        logic [OPS-1:0]          dv;
    } res_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fu_valid [FUS];
    logic           fu_ready [FUS];
    logic [IDB-1:0] fu_id    [FUS];
    logic [PB-1:0]  fu_prn   [FUS][OPS];
    logic [63:0]    fu_data  [FUS][OPS];
    logic           fu_dv    [FUS][OPS];
    logic           wb_valid;
    logic           wb_ready;
    logic [IDB-1:0] wb_inst_id;
    logic [PB-1:0]  wb_prn   [OPS];
    logic [63:0]    wb_data  [OPS];
    logic           wb_dv    [OPS];
    logic [IXB-1:0] wb_fu_index;

    int checks = 0;
    int errors = 0;

    // reference model state
    res_t q [FUS][$];
    bit   m_acc [FUS];
    bit   m_valid = 1'b0;
    res_t m_res = '0;
    int   m_fu = 0;
    int   m_rr = 0;
    int   m_g;

    // contention-phase driver state
    bit       pending [FUS];
    bit       acc     [FUS];
    logic [5:0] nid   [FUS];

    wb_result_arbiter #(
        .INST_ID_BITS(IDB), .PRN_BITS(PB), .MAX_OPERANDS(OPS),
        .FU_COUNT(FUS), .FU_IDX_BITS(IXB)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_in_valid(fu_valid), .fu_in_ready(fu_ready), .fu_in_inst_id(fu_id),
        .fu_in_prn(fu_prn), .fu_in_data(fu_data), .fu_in_data_valid(fu_dv),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_inst_id(wb_inst_id),
        .wb_prn(wb_prn), .wb_data(wb_data), .wb_data_valid(wb_dv),
        .wb_fu_index(wb_fu_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ready_vec();
        return {fu_ready[3], fu_ready[2], fu_ready[1], fu_ready[0]};
    endfunction

    function automatic logic [2:0] dv_vec();
        return {wb_dv[2], wb_dv[1], wb_dv[0]};
    endfunction

    function automatic res_t fu_res(input int f);
        res_t r;
        r.id = fu_id[f];
        for (int k = 0; k < OPS; k++) begin
            r.prn[k]  = fu_prn[f][k];
            r.data[k] = fu_data[f][k];
            r.dv[k]   = fu_dv[f][k];
        end
        return r;
    endfunction

    // Model: FIFOs are plain queues of at most two; the grant is the first
    // non-empty queue found walking round from the pointer.
    task automatic model_step();
        for (int i = 0; i < FUS; i++) m_acc[i] = fu_valid[i] && (q[i].size() < 2);
        if (!m_valid || wb_ready) begin
            m_g = -1;
            for (int k = 0; k < FUS; k++) begin
                if (m_g < 0 && q[(m_rr + k) % FUS].size() != 0) m_g = (m_rr + k) % FUS;
            end
            if (m_g >= 0) begin
                m_res   = q[m_g].pop_front();
                m_valid = 1'b1;
                m_fu    = m_g;
                m_rr    = (m_g + 1) % FUS;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < FUS; i++) if (m_acc[i]) q[i].push_back(fu_res(i));
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < FUS; i++) q[i].delete();
                m_valid = 1'b0;
                m_res   = '0;
                m_fu    = 0;
                m_rr    = 0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("m_wb_valid", 64'(wb_valid), 64'(m_valid));
                for (int i = 0; i < FUS; i++)
                    check($sformatf("m_ready%0d", i), 64'(fu_ready[i]), 64'(q[i].size() < 2));
                if (m_valid) begin
                    check("m_inst_id", 64'(wb_inst_id), 64'(m_res.id));
                    check("m_fu_index", 64'(wb_fu_index), 64'(m_fu));
                    for (int k = 0; k < OPS; k++) begin
                        check($sformatf("m_prn%0d", k), 64'(wb_prn[k]), 64'(m_res.prn[k]));
                        check($sformatf("m_data%0d", k), wb_data[k], m_res.data[k]);
                        check($sformatf("m_dv%0d", k), 64'(wb_dv[k]), 64'(m_res.dv[k]));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fu();
        for (int i = 0; i < FUS; i++) fu_valid[i] = 1'b0;
    endtask

    task automatic set_fu(input int f, input logic [IDB-1:0] id, input logic [PB-1:0] p0,
                          input logic [63:0] d0, input logic [2:0] dv);
        fu_valid[f] = 1'b1;
        fu_id[f]    = id;
        for (int k = 0; k < OPS; k++) begin
            fu_dv[f][k] = dv[k];
            if (k == 0) begin
                fu_prn[f][k]  = p0;
                fu_data[f][k] = d0;
            end else begin
                fu_prn[f][k]  = dv[k] ? PB'(int'(p0) + k) : '0;
                fu_data[f][k] = dv[k] ? d0 + 64'(k) : '0;
            end
        end
    endtask

    initial begin
        wb_ready = 1'b1;
        for (int i = 0; i < FUS; i++) begin
            fu_valid[i] = 1'b0;
            fu_id[i]    = '0;
            pending[i]  = 1'b0;
            acc[i]      = 1'b0;
            nid[i]      = 6'(8 * i);
            for (int k = 0; k < OPS; k++) begin
                fu_prn[i][k]  = '0;
                fu_data[i][k] = '0;
                fu_dv[i][k]   = 1'b0;
            end
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_ready", 64'(ready_vec()), 64'hF);
        check("rst_inst_id", 64'(wb_inst_id), 64'd0);
        check("rst_fu_index", 64'(wb_fu_index), 64'd0);
        check("rst_dv", 64'(dv_vec()), 64'd0);
        check("rst_prn0", 64'(wb_prn[0]), 64'd0);
        check("rst_data0", wb_data[0], 64'd0);
        #2 rst = 1'b0;

        // idle
        for (int c = 0; c < 4; c++) begin
            tick();
            check("idle_valid", 64'(wb_valid), 64'd0);
            check("idle_ready", 64'(ready_vec()), 64'hF);
        end

        // round-robin from pointer 0
        for (int f = 0; f < FUS; f++) set_fu(f, IDB'(10 + f), PB'(20 + f), 64'h100 + 64'(f), 3'b001);
        tick();
        clear_fu();
        check("rr0_push_valid", 64'(wb_valid), 64'd0);
        for (int s = 0; s < FUS; s++) begin
            tick();
            check("rr0_valid", 64'(wb_valid), 64'd1);
            check("rr0_id", 64'(wb_inst_id), 64'(10 + s));
            check("rr0_fu", 64'(wb_fu_index), 64'(s));
        end
        tick();
        check("rr0_end_valid", 64'(wb_valid), 64'd0);

        // move the pointer to 2 with a lone FU1 result, then contend again
        set_fu(1, 6'd30, 6'd31, 64'h3030, 3'b011);
        tick();
        clear_fu();
        tick();
        check("rr2_pre_id", 64'(wb_inst_id), 64'd30);
        for (int f = 0; f < FUS; f++) set_fu(f, IDB'(10 + f), PB'(20 + f), 64'h200 + 64'(f), 3'b101);
        tick();
        clear_fu();
        check("rr2_push_valid", 64'(wb_valid), 64'd0);
        begin
            int exp_seq [4] = '{12, 13, 10, 11};
            for (int s = 0; s < FUS; s++) begin
                tick();
                check("rr2_valid", 64'(wb_valid), 64'd1);
                check("rr2_id", 64'(wb_inst_id), 64'(exp_seq[s]));
                check("rr2_fu", 64'(wb_fu_index), 64'(exp_seq[s] - 10));
            end
        end
        tick();
        check("rr2_end_valid", 64'(wb_valid), 64'd0);

        // single result latency
        set_fu(2, 6'd5, 6'd7, 64'hDEAD, 3'b001);
        tick();
        clear_fu();
        check("single_n1_valid", 64'(wb_valid), 64'd0);
        tick();
        check("single_valid", 64'(wb_valid), 64'd1);
        check("single_id", 64'(wb_inst_id), 64'd5);
        check("single_fu", 64'(wb_fu_index), 64'd2);
        check("single_prn0", 64'(wb_prn[0]), 64'd7);
        check("single_prn1", 64'(wb_prn[1]), 64'd0);
        check("single_data0", wb_data[0], 64'hDEAD);
        check("single_dv", 64'(dv_vec()), 64'b001);
        tick();
        check("single_n3_valid", 64'(wb_valid), 64'd0);

        // backpressure on FU1
        wb_ready = 1'b0;
        check("bp_ready_pre", 64'(fu_ready[1]), 64'd1);
        set_fu(1, 6'd1, 6'd11, 64'h11, 3'b001);
        tick();
        set_fu(1, 6'd2, 6'd12, 64'h12, 3'b001);
        tick();
        check("bp_hold_id1", 64'(wb_inst_id), 64'd1);
        check("bp_ready_one", 64'(fu_ready[1]), 64'd1);
        set_fu(1, 6'd3, 6'd13, 64'h13, 3'b001);
        tick();
        clear_fu();
        check("bp_full_ready", 64'(fu_ready[1]), 64'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("bp_stall_valid", 64'(wb_valid), 64'd1);
            check("bp_stall_id", 64'(wb_inst_id), 64'd1);
            check("bp_stall_ready", 64'(fu_ready[1]), 64'd0);
        end
        wb_ready = 1'b1;
        tick();
        check("bp_rel_id2", 64'(wb_inst_id), 64'd2);
        check("bp_rel_ready", 64'(fu_ready[1]), 64'd1);
        tick();
        check("bp_rel_id3", 64'(wb_inst_id), 64'd3);
        tick();
        check("bp_rel_end", 64'(wb_valid), 64'd0);

        // single FU streaming at one result per cycle
        for (int s = 0; s < 6; s++) begin
            check("stream_ready", 64'(fu_ready[3]), 64'd1);
            set_fu(3, IDB'(50 + s), PB'(s), 64'h5000 + 64'(s), 3'b111);
            tick();
            if (s > 0) check("stream_id", 64'(wb_inst_id), 64'(50 + s - 1));
        end
        clear_fu();
        tick();
        check("stream_last", 64'(wb_inst_id), 64'd55);
        tick();
        check("stream_end", 64'(wb_valid), 64'd0);

        // result with no register writes
        set_fu(0, 6'd60, 6'd3, 64'h1234, 3'b000);
        tick();
        clear_fu();
        tick();
        check("noreg_valid", 64'(wb_valid), 64'd1);
        check("noreg_id", 64'(wb_inst_id), 64'd60);
        check("noreg_dv", 64'(dv_vec()), 64'd0);
        tick();
        check("noreg_end", 64'(wb_valid), 64'd0);

        // mixed contention with a fixed wb_ready stall pattern
        for (int cyc = 0; cyc < 48; cyc++) begin
            logic [15:0] pat;
            pat = 16'b1011_0010_1110_0110;
            wb_ready = pat[cyc % 16];
            for (int f = 0; f < FUS; f++) begin
                if (!pending[f] && ((cyc + f) % 3 != 0)) begin
                    pending[f] = 1'b1;
                    set_fu(f, nid[f], PB'(nid[f]), 64'hA5A5_0000_0000_0000 + 64'(nid[f]),
                           3'((cyc + f) % 8));
                end
                acc[f] = pending[f] && fu_ready[f];
            end
            tick();
            for (int f = 0; f < FUS; f++) begin
                if (acc[f]) begin
                    pending[f]  = 1'b0;
                    fu_valid[f] = 1'b0;
                    nid[f]      = nid[f] + 6'd1;
                end
            end
        end
        clear_fu();
        wb_ready = 1'b1;
        repeat (12) tick();
        check("mix_drained", 64'(wb_valid), 64'd0);

        // asynchronous reset in the middle of a stall
        wb_ready = 1'b0;
        set_fu(0, 6'd40, 6'd1, 64'h40, 3'b001);
        set_fu(3, 6'd43, 6'd2, 64'h43, 3'b001);
        tick();
        fu_valid[3] = 1'b0;
        set_fu(0, 6'd41, 6'd1, 64'h41, 3'b001);
        tick();
        clear_fu();
        check("arst_pre_valid", 64'(wb_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(wb_valid), 64'd0);
        check("arst_ready", 64'(ready_vec()), 64'hF);
        check("arst_id", 64'(wb_inst_id), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        wb_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("arst_no_stale", 64'(wb_valid), 64'd0);
            check("arst_ready_after", 64'(ready_vec()), 64'hF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
